// File: rtl/pcie_wrr_arb_pkg.sv
// Shared definitions for the PCIe weighted round-robin posted-write arbiter:
// config register offsets, size limits and the arbiter state encoding.
package pcie_wrr_arb_pkg;

    localparam int MAX_CH   = 8;
    localparam int WEIGHT_W = 4;
    localparam int COUNT_W  = 16;

    localparam logic [7:0] REG_CTRL        = 8'h00;
    localparam logic [7:0] REG_MASK        = 8'h04;
    localparam logic [7:0] REG_STATUS      = 8'h08;
    localparam logic [7:0] REG_WEIGHT_BASE = 8'h10;
    localparam logic [7:0] REG_COUNT_BASE  = 8'h40;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_e;

endpackage

// File: rtl/pcie_wrr_arbiter_if.sv
// Bus bundle for pcie_wrr_arbiter.
//   req*           : N_CH flattened posted-write request channels (valid/ready)
//   Arb*           : Avalon-MM write master toward PCIe, plus granted channel
//   ArbConf*       : Avalon-MM config slave (8-bit byte address, 32-bit data)
// Modport master is the arbiter's view; slave is the surrounding system.
interface pcie_wrr_arbiter_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 64
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]        reqValid;
    logic [N_CH-1:0]        reqReady;
    logic [N_CH*ADDR_W-1:0] reqAddr;
    logic [N_CH*32-1:0]     reqData;
    logic [N_CH*4-1:0]      reqByteEnable;

    logic [ADDR_W-1:0]      ArbAddress;
    logic [31:0]            ArbWriteData;
    logic [3:0]             ArbByteEnable;
    logic                   ArbChipSelect;
    logic                   ArbWrite;
    logic                   ArbWaitRequest;
    logic [CH_W-1:0]        ArbGrantCh;

    logic                   ArbConfChipSelect_i;
    logic                   ArbConfWrite_i;
    logic                   ArbConfRead_i;
    logic [7:0]             ArbConfAddress_i;
    logic [31:0]            ArbConfWriteData_i;
    logic [3:0]             ArbConfByteEnable_i;
    logic [31:0]            ArbConfReadData_o;
    logic                   ArbConfWaitRequest_o;

    modport master (
        input  reqValid, reqAddr, reqData, reqByteEnable, ArbWaitRequest,
               ArbConfChipSelect_i, ArbConfWrite_i, ArbConfRead_i,
               ArbConfAddress_i, ArbConfWriteData_i, ArbConfByteEnable_i,
        output reqReady, ArbAddress, ArbWriteData, ArbByteEnable,
               ArbChipSelect, ArbWrite, ArbGrantCh,
               ArbConfReadData_o, ArbConfWaitRequest_o
    );

    modport slave (
        output reqValid, reqAddr, reqData, reqByteEnable, ArbWaitRequest,
               ArbConfChipSelect_i, ArbConfWrite_i, ArbConfRead_i,
               ArbConfAddress_i, ArbConfWriteData_i, ArbConfByteEnable_i,
        input  reqReady, ArbAddress, ArbWriteData, ArbByteEnable,
               ArbChipSelect, ArbWrite, ArbGrantCh,
               ArbConfReadData_o, ArbConfWaitRequest_o
    );
endinterface

// File: rtl/pcie_wrr_rr_pick.sv
// Rotating-priority encoder: returns the first set bit of eligible found by
// scanning upward from pointer and wrapping modulo N_CH.
//   eligible : per-channel request-eligible vector
//   pointer  : channel with highest priority this cycle
//   hit      : at least one channel eligible
//   index    : winning channel (0 when no hit)
module pcie_wrr_rr_pick #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] eligible,
    input  logic [CH_W-1:0] pointer,
    output logic            hit,
    output logic [CH_W-1:0] index
);
    int j;

    // Walk from farthest to nearest so the nearest eligible channel is the
    // last assignment and therefore wins.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        j     = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            j = int'(pointer) + k;
            if (j >= N_CH) j = j - N_CH;
            if (eligible[j]) begin
                hit   = 1'b1;
                index = CH_W'(j);
            end
        end
    end
endmodule

// File: rtl/pcie_wrr_arbiter.sv
// Weighted round-robin arbiter merging N_CH posted-write request channels onto
// one PCIe Avalon-MM write master, with an Avalon-MM config slave
// (CTRL, MASK, STATUS, WEIGHT[i], COUNT[i]).
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : pcie_wrr_arbiter_if.master (request channels, write master,
//                  config slave)
// Optional: define PCIE_WRR_ARB_STATS_EN to build per-channel saturating
// beat counters readable at COUNT[i]; otherwise COUNT reads 0.
//
// state | meaning
// IDLE  | no beat on the master; accept the first eligible channel from rrPtr
// BUSY  | beat of grantCh on the master; held while ArbWaitRequest is high
module pcie_wrr_arbiter
    import pcie_wrr_arb_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 64
) (
    input logic                clock,
    input logic                reset,
    pcie_wrr_arbiter_if.master bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    arbState_e           state;
    logic [CH_W-1:0]     grantCh, rrPtr, nextPtr, pickPtr, pickIdx, acceptCh;
    logic [WEIGHT_W-1:0] burstCnt, effWeight;
    logic [WEIGHT_W-1:0] weight [N_CH];
    logic [N_CH-1:0]     mask, eligible, reqReadyC;
    logic                ctrlEn, pickHit, acceptValid, beatDone, sameOk;

    logic [ADDR_W-1:0]   addrQ;
    logic [31:0]         dataQ;
    logic [3:0]          beQ;
    logic                chipSelQ;

    logic                cfgWr, cfgRdStart, rdPending;
    logic [31:0]         rdMux, rdDataQ;

    assign eligible  = bus.reqValid & mask & {N_CH{ctrlEn}};
    assign nextPtr   = (grantCh == CH_W'(N_CH - 1)) ? '0 : grantCh + CH_W'(1);
    assign effWeight = (weight[grantCh] == '0) ? WEIGHT_W'(1) : weight[grantCh];
    assign beatDone  = (state == BUSY) && !bus.ArbWaitRequest;
    assign sameOk    = (burstCnt < effWeight) && eligible[grantCh];
    // While a beat is finishing, the next winner is searched from the channel
    // after the current owner.
    assign pickPtr   = (state == BUSY) ? nextPtr : rrPtr;

    pcie_wrr_rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) uPick (
        .eligible (eligible),
        .pointer  (pickPtr),
        .hit      (pickHit),
        .index    (pickIdx)
    );

    always_comb begin
        acceptValid = 1'b0;
        acceptCh    = pickIdx;
        if (state == IDLE) begin
            acceptValid = pickHit;
        end else if (beatDone) begin
            if (sameOk) begin
                acceptValid = 1'b1;
                acceptCh    = grantCh;
            end else begin
                acceptValid = pickHit;
            end
        end
    end

    always_comb begin
        reqReadyC = '0;
        if (acceptValid) reqReadyC[acceptCh] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grantCh  <= '0;
            rrPtr    <= '0;
            burstCnt <= '0;
            addrQ    <= '0;
            dataQ    <= '0;
            beQ      <= '0;
            chipSelQ <= 1'b0;
        end else if (acceptValid) begin
            state    <= BUSY;
            grantCh  <= acceptCh;
            chipSelQ <= 1'b1;
            addrQ    <= bus.reqAddr[int'(acceptCh)*ADDR_W +: ADDR_W];
            dataQ    <= bus.reqData[int'(acceptCh)*32 +: 32];
            beQ      <= bus.reqByteEnable[int'(acceptCh)*4 +: 4];
            if (state == BUSY && sameOk) begin
                burstCnt <= burstCnt + WEIGHT_W'(1);
            end else begin
                burstCnt <= WEIGHT_W'(1);
            end
            if (state == BUSY && !sameOk) rrPtr <= nextPtr;
        end else if (beatDone) begin
            state    <= IDLE;
            chipSelQ <= 1'b0;
            burstCnt <= '0;
            rrPtr    <= nextPtr;
        end
    end

    assign bus.reqReady      = reqReadyC;
    assign bus.ArbAddress    = addrQ;
    assign bus.ArbWriteData  = dataQ;
    assign bus.ArbByteEnable = beQ;
    assign bus.ArbChipSelect = chipSelQ;
    assign bus.ArbWrite      = chipSelQ;
    assign bus.ArbGrantCh    = grantCh;

    // Config slave: writes complete immediately, reads take two cycles.
    assign cfgWr      = bus.ArbConfChipSelect_i && bus.ArbConfWrite_i;
    assign cfgRdStart = bus.ArbConfChipSelect_i && bus.ArbConfRead_i && !rdPending;

`ifdef PCIE_WRR_ARB_STATS_EN
    logic [COUNT_W-1:0] countQ [N_CH];

    // A COUNT write in the same cycle as a completing beat clears the counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) countQ[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfgWr && bus.ArbConfAddress_i == REG_COUNT_BASE + 8'(4*i)) begin
                    countQ[i] <= '0;
                end else if (beatDone && grantCh == CH_W'(i) && countQ[i] != '1) begin
                    countQ[i] <= countQ[i] + COUNT_W'(1);
                end
            end
        end
    end
`endif

    // Exact-address compares leave unaligned, unmapped and out-of-range
    // channel offsets reading as zero.
    always_comb begin
        rdMux = '0;
        case (bus.ArbConfAddress_i)
            REG_CTRL:   rdMux[0] = ctrlEn;
            REG_MASK:   rdMux[N_CH-1:0] = mask;
            REG_STATUS: begin
                rdMux[0]         = (state == BUSY);
                rdMux[8 +: CH_W] = grantCh;
            end
            default: ;
        endcase
        for (int i = 0; i < N_CH; i++) begin
            if (bus.ArbConfAddress_i == REG_WEIGHT_BASE + 8'(4*i)) begin
                rdMux[WEIGHT_W-1:0] = weight[i];
            end
`ifdef PCIE_WRR_ARB_STATS_EN
            if (bus.ArbConfAddress_i == REG_COUNT_BASE + 8'(4*i)) begin
                rdMux[COUNT_W-1:0] = countQ[i];
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrlEn    <= 1'b1;
            mask      <= '1;
            rdPending <= 1'b0;
            rdDataQ   <= '0;
            for (int i = 0; i < N_CH; i++) weight[i] <= WEIGHT_W'(1);
        end else begin
            rdPending <= cfgRdStart;
            rdDataQ   <= cfgRdStart ? rdMux : '0;
            // Every writable field sits in byte lane 0.
            if (cfgWr && bus.ArbConfByteEnable_i[0]) begin
                if (bus.ArbConfAddress_i == REG_CTRL) ctrlEn <= bus.ArbConfWriteData_i[0];
                if (bus.ArbConfAddress_i == REG_MASK) mask <= bus.ArbConfWriteData_i[N_CH-1:0];
                for (int i = 0; i < N_CH; i++) begin
                    if (bus.ArbConfAddress_i == REG_WEIGHT_BASE + 8'(4*i)) begin
                        weight[i] <= bus.ArbConfWriteData_i[WEIGHT_W-1:0];
                    end
                end
            end
        end
    end

    assign bus.ArbConfReadData_o    = rdDataQ;
    assign bus.ArbConfWaitRequest_o = cfgRdStart;
endmodule

// File: tb/tb_pcie_wrr_arbiter.sv
module tb_pcie_wrr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passCnt = 0;
    int   checkCnt = 0;

    always #5 clk = ~clk;

    pcie_wrr_arbiter_if #(.N_CH(4), .ADDR_W(64)) bus ();

    pcie_wrr_arbiter #(.N_CH(4), .ADDR_W(64)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic doReset();
        rst = 1'b1;
        bus.reqValid       = '0;
        bus.ArbWaitRequest = 1'b0;
        bus.ArbConfChipSelect_i = 1'b0;
        bus.ArbConfWrite_i = 1'b0;
        bus.ArbConfRead_i  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic confWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.ArbConfChipSelect_i = 1'b1;
        bus.ArbConfWrite_i      = 1'b1;
        bus.ArbConfAddress_i    = a;
        bus.ArbConfWriteData_i  = d;
        bus.ArbConfByteEnable_i = be;
        @(posedge clk);
        #1;
        bus.ArbConfChipSelect_i = 1'b0;
        bus.ArbConfWrite_i      = 1'b0;
    endtask

    task automatic confRead(input logic [7:0] a, output logic [31:0] d, output logic firstWait);
        bus.ArbConfChipSelect_i = 1'b1;
        bus.ArbConfRead_i       = 1'b1;
        bus.ArbConfAddress_i    = a;
        #1 firstWait = bus.ArbConfWaitRequest_o;
        @(posedge clk);
        #1 d = bus.ArbConfReadData_o;
        @(posedge clk);
        #1;
        bus.ArbConfChipSelect_i = 1'b0;
        bus.ArbConfRead_i       = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passCnt++;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic w;
        doReset();
        chk("rst_cs", 64'(bus.ArbChipSelect), 64'd0);
        chk("rst_write", 64'(bus.ArbWrite), 64'd0);
        chk("rst_grant", 64'(bus.ArbGrantCh), 64'd0);
        chk("rst_ready", 64'(bus.reqReady), 64'd0);
        chk("rst_rdata_idle", 64'(bus.ArbConfReadData_o), 64'd0);
        confRead(8'h00, d, w);
        chk("rst_ctrl", 64'(d), 64'd1);
        chk("rd_first_wait", 64'(w), 64'd1);
        confRead(8'h04, d, w);
        chk("rst_mask", 64'(d), 64'hF);
        confRead(8'h1C, d, w);
        chk("rst_weight3", 64'(d), 64'd1);
        confRead(8'h20, d, w);
        chk("weight4_oob", 64'(d), 64'd0);
        confRead(8'h05, d, w);
        chk("unaligned_rd", 64'(d), 64'd0);
        confRead(8'h0C, d, w);
        chk("unmapped_rd", 64'(d), 64'd0);
        confRead(8'h08, d, w);
        chk("rst_status", 64'(d), 64'd0);
        confWrite(8'h04, 32'h0, 4'hE);
        confWrite(8'h05, 32'h0, 4'hF);
        confRead(8'h04, d, w);
        chk("mask_be_unaligned", 64'(d), 64'hF);
    endtask

    task automatic test_round_robin();
        int expG[5] = '{0, 1, 2, 3, 0};
        doReset();
        bus.reqValid = 4'hF;
        #1 chk("rr_ready0", 64'(bus.reqReady), 64'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr_grant%0d", i), 64'(bus.ArbGrantCh), 64'(expG[i]));
            chk($sformatf("rr_cs%0d", i), 64'(bus.ArbChipSelect), 64'd1);
        end
        chk("rr_addr0", 64'(bus.ArbAddress), 64'h1000);
        bus.reqValid = '0;
        @(posedge clk);
        #1 chk("rr_idle_cs", 64'(bus.ArbChipSelect), 64'd0);
    endtask

    task automatic test_weight();
        int expG[8] = '{1, 1, 1, 2, 1, 1, 1, 2};
        doReset();
        confWrite(8'h14, 32'd3, 4'hF);
        bus.reqValid = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 chk($sformatf("wt_grant%0d", i), 64'(bus.ArbGrantCh), 64'(expG[i]));
        end
        bus.reqValid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        doReset();
        bus.ArbWaitRequest = 1'b1;
        bus.reqValid = 4'b0001;
        #1 chk("st_ready_idle", 64'(bus.reqReady), 64'h1);
        @(posedge clk);
        #1 bus.reqValid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("st_addr%0d", i), 64'(bus.ArbAddress), 64'h1000);
            chk($sformatf("st_data%0d", i), 64'(bus.ArbWriteData), 64'hDEADBEEF);
            chk($sformatf("st_cs%0d", i), 64'({bus.ArbChipSelect, bus.ArbWrite}), 64'h3);
            chk($sformatf("st_ready%0d", i), 64'(bus.reqReady), 64'h0);
        end
        bus.ArbWaitRequest = 1'b0;
        #1 chk("st_release_ready", 64'(bus.reqReady), 64'h2);
        @(posedge clk);
        #1;
        chk("st_next_grant", 64'(bus.ArbGrantCh), 64'd1);
        chk("st_next_addr", 64'(bus.ArbAddress), 64'h1100);
        bus.reqValid = '0;
        @(posedge clk);
        #1 chk("st_idle_cs", 64'(bus.ArbChipSelect), 64'd0);
    endtask

    task automatic test_mask();
        int expG[4] = '{0, 1, 0, 1};
        logic [31:0] d;
        logic w;
        doReset();
        bus.reqValid = 4'b0111;
        repeat (3) @(posedge clk);
        #1;
        chk("mk_grant2", 64'(bus.ArbGrantCh), 64'd2);
        bus.ArbWaitRequest = 1'b1;
        confWrite(8'h04, 32'hB, 4'h1);
        chk("mk_beat_held", 64'({bus.ArbChipSelect, bus.ArbGrantCh}), 64'h6);
        confRead(8'h08, d, w);
        chk("mk_status_busy", 64'(d), 64'h201);
        bus.ArbWaitRequest = 1'b0;
        #1 chk("mk_ready_after", 64'(bus.reqReady), 64'h1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk($sformatf("mk_grant_after%0d", i), 64'(bus.ArbGrantCh), 64'(expG[i]));
        end
        bus.reqValid = '0;
        @(posedge clk);
        #1;
        confRead(8'h08, d, w);
        chk("mk_status_idle", 64'(d), 64'h100);
    endtask

    task automatic test_ctrl_disable();
        logic [31:0] d;
        logic w;
        doReset();
        confWrite(8'h00, 32'h0, 4'hF);
        bus.reqValid = 4'b0001;
        #1 chk("dis_ready", 64'(bus.reqReady), 64'h0);
        @(posedge clk);
        #1 chk("dis_cs", 64'(bus.ArbChipSelect), 64'd0);
        confWrite(8'h00, 32'h1, 4'hF);
        chk("en_ready", 64'(bus.reqReady), 64'h1);
        bus.reqValid = '0;
        @(posedge clk);
        #1;
        confRead(8'h00, d, w);
        chk("en_ctrl", 64'(d), 64'd1);
    endtask

    task automatic test_reset_busy();
        logic [31:0] d;
        logic w;
        doReset();
        confWrite(8'h04, 32'h3, 4'hF);
        confWrite(8'h10, 32'h5, 4'hF);
        bus.ArbWaitRequest = 1'b1;
        bus.reqValid = 4'b0001;
        @(posedge clk);
        #1 chk("rb_cs_before", 64'(bus.ArbChipSelect), 64'd1);
        rst = 1'b1;
        #1;
        chk("rb_cs_async", 64'({bus.ArbChipSelect, bus.ArbWrite}), 64'd0);
        bus.reqValid = '0;
        bus.ArbWaitRequest = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        confRead(8'h04, d, w);
        chk("rb_mask", 64'(d), 64'hF);
        confRead(8'h10, d, w);
        chk("rb_weight0", 64'(d), 64'd1);
    endtask

    task automatic test_stats();
        logic [31:0] d;
        logic w;
        doReset();
        bus.reqValid = 4'b0001;
        repeat (3) @(posedge clk);
        #1 bus.reqValid = '0;
        @(posedge clk);
        #1;
        confRead(8'h40, d, w);
`ifdef PCIE_WRR_ARB_STATS_EN
        chk("cnt_three", 64'(d), 64'd3);
        confRead(8'h44, d, w);
        chk("cnt_ch1_zero", 64'(d), 64'd0);
        doReset();
        bus.reqValid = 4'b0001;
        repeat (32'h10002) @(posedge clk);
        #1 bus.reqValid = '0;
        @(posedge clk);
        #1;
        confRead(8'h40, d, w);
        chk("cnt_saturate", 64'(d), 64'hFFFF);
        confWrite(8'h40, 32'h0, 4'hF);
        confRead(8'h40, d, w);
        chk("cnt_clear", 64'(d), 64'd0);
`else
        chk("cnt_absent", 64'(d), 64'd0);
`endif
    endtask

    initial begin
        bus.reqValid            = '0;
        bus.reqAddr             = {64'h1300, 64'h1200, 64'h1100, 64'h1000};
        bus.reqData             = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        bus.reqByteEnable       = {4'h8, 4'h4, 4'h3, 4'hF};
        bus.ArbWaitRequest      = 1'b0;
        bus.ArbConfChipSelect_i = 1'b0;
        bus.ArbConfWrite_i      = 1'b0;
        bus.ArbConfRead_i       = 1'b0;
        bus.ArbConfAddress_i    = '0;
        bus.ArbConfWriteData_i  = '0;
        bus.ArbConfByteEnable_i = '0;
        test_reset();
        test_round_robin();
        test_weight();
        test_stall();
        test_mask();
        test_ctrl_disable();
        test_reset_busy();
        test_stats();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
